// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: word geometry,
// FSM state encoding and the byte-lane merge used on write and bypass paths.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } dmem_state_e;

  // Lanes with mask[k]=1 take the new byte; all other lanes keep the old byte.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [MASK_W-1:0] mask
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int k = 0; k < MASK_W; k++) begin
      if (mask[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge; one instance feeds both the array write
// value and the write-first read bypass.
module dmem_byte_merge
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] i_old,
  input  logic [WORD_W-1:0] i_new,
  input  logic [MASK_W-1:0] i_mask,
  output logic [WORD_W-1:0] o_merged
);

  assign o_merged = byte_merge(i_old, i_new, i_mask);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-fills the array after reset (optional), then
// serves one masked write and one registered write-first read per cycle.
// Interface: no handshake on the request side; a request is taken every cycle
// while o_ready is high, and o_rd_data/o_addr_err answer it one cycle later.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [29:0]       i_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic [MASK_W-1:0] i_mask,
  input  logic              i_we,
  output logic [WORD_W-1:0] o_rd_data,
  output logic              o_addr_err,
  output logic              o_ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];

  dmem_state_e       r_state;
  dmem_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_addr_err;
  logic              r_ready;

  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic [WORD_W-1:0] w_old;
  logic [MASK_W-1:0] w_eff_mask;
  logic [WORD_W-1:0] w_merged;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_idx;
  logic [WORD_W-1:0] w_mem_val;
  logic [WORD_W-1:0] w_rd_nxt;
  logic              w_err_nxt;

  assign w_in_range = ((i_addr >> ADDR_W) == '0);
  assign w_idx      = i_addr[ADDR_W-1:0];
  assign w_old      = r_mem[w_idx];
  // A zero mask turns the merge into a plain read of the old word.
  assign w_eff_mask = (r_state == ST_SERVE && i_we && w_in_range) ? i_mask : '0;

  dmem_byte_merge u_merge (
    .i_old    (w_old),
    .i_new    (i_wr_data),
    .i_mask   (w_eff_mask),
    .o_merged (w_merged)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= INIT_ON_RESET ? ST_CLEAR : ST_SERVE;
      r_clr_cnt  <= '0;
      r_rd_data  <= '0;
      r_addr_err <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : r_clr_cnt;
      r_rd_data  <= w_rd_nxt;
      r_addr_err <= w_err_nxt;
      r_ready    <= (w_state_nxt == ST_SERVE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_SERVE;
  end

  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_idx = w_idx;
    w_mem_val = w_merged;
    w_rd_nxt  = '0;
    w_err_nxt = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we  = 1'b1;
        w_mem_idx = r_clr_cnt;
        w_mem_val = '0;
      end
      ST_SERVE: begin
        w_mem_we  = i_we && w_in_range;
        w_rd_nxt  = w_in_range ? w_merged : '0;
        w_err_nxt = !w_in_range;
      end
      default: ;
    endcase
  end

  // Single write port shared by the zero-fill and normal stores.
  always_ff @(posedge i_clk) begin
    if (w_mem_we && !i_rst) r_mem[w_mem_idx] <= w_mem_val;
  end

  assign o_rd_data  = r_rd_data;
  assign o_addr_err = r_addr_err;
  assign o_ready    = r_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder (ADDR_W=4), with one
// instance zero-filling on reset and one starting directly in SERVE.
module tb_dmem_responder;

  logic        clk;
  logic        a_rst, b_rst;
  logic [29:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [3:0]  a_mask, b_mask;
  logic        a_we, b_we;
  logic [31:0] a_rd, b_rd;
  logic        a_err, b_err;
  logic        a_rdy, b_rdy;

  int check_cnt = 0;
  int error_cnt = 0;

  logic [33:0] exp_q[$];
  logic [31:0] m_mem [16];
  bit          m_serve;
  int          m_clear_left;

  dmem_responder #(.ADDR_W(4), .INIT_ON_RESET(1'b1)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_addr(a_addr), .i_wr_data(a_wdata),
    .i_mask(a_mask), .i_we(a_we), .o_rd_data(a_rd), .o_addr_err(a_err),
    .o_ready(a_rdy)
  );

  dmem_responder #(.ADDR_W(4), .INIT_ON_RESET(1'b0)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_addr(b_addr), .i_wr_data(b_wdata),
    .i_mask(b_mask), .i_we(b_we), .o_rd_data(b_rd), .o_addr_err(b_err),
    .o_ready(b_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      error_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    a_we  = 1'b0;
    @(posedge clk); #1;
    m_serve      = 1'b0;
    m_clear_left = 16;
    exp_q.delete();
    chk("rst_ready", {31'd0, a_rdy}, 32'd0);
    chk("rst_rd",    a_rd,           32'd0);
    chk("rst_err",   {31'd0, a_err}, 32'd0);
    a_rst = 1'b0;
  endtask

  // One request cycle: model predicts the response, DUT answer is checked after the edge.
  task automatic step(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                      input logic w);
    logic [31:0] e_rd;
    logic        e_err;
    logic [33:0] e;
    if (!m_serve) begin
      e_rd  = 32'd0;
      e_err = 1'b0;
      m_clear_left--;
      if (m_clear_left == 0) begin
        m_serve = 1'b1;
        foreach (m_mem[i]) m_mem[i] = 32'd0;
      end
    end else if (a < 16) begin
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (m[k]) m_mem[a[3:0]][8*k +: 8] = d[8*k +: 8];
      end
      e_rd  = m_mem[a[3:0]];
      e_err = 1'b0;
    end else begin
      e_rd  = 32'd0;
      e_err = 1'b1;
    end
    exp_q.push_back({m_serve, e_err, e_rd});
    a_addr = a; a_wdata = d; a_mask = m; a_we = w;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("ready", {31'd0, a_rdy}, {31'd0, e[33]});
    chk("err",   {31'd0, a_err}, {31'd0, e[32]});
    chk("rd",    a_rd,           e[31:0]);
  endtask

  initial begin
    logic [31:0] bval;
    a_rst = 1'b1; b_rst = 1'b1;
    a_addr = '0; a_wdata = '0; a_mask = '0; a_we = 1'b0;
    b_addr = '0; b_wdata = '0; b_mask = '0; b_we = 1'b0;
    @(posedge clk); #1;
    reset_a();

    // Zero-fill: a write attempt to word 3 must be ignored.
    for (int i = 0; i < 16; i++) begin
      if (i == 2) step(30'd3, 32'hFFFF_FFFF, 4'hF, 1'b1);
      else        step(30'd0, 32'd0, 4'h0, 1'b0);
      chk("clear_ready_const", {31'd0, a_rdy}, (i == 15) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      step(30'(i), 32'd0, 4'h0, 1'b0);
      chk("zero_fill", a_rd, 32'd0);
    end

    step(30'd5, 32'hAABB_CCDD, 4'b1111, 1'b1);
    step(30'd5, 32'h1122_3344, 4'b0101, 1'b1);
    step(30'd5, 32'd0, 4'b0000, 1'b0);
    chk("mask_merge", a_rd, 32'hAA22_CC44);
    step(30'd5, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    chk("mask_zero_noop", a_rd, 32'hAA22_CC44);

    step(30'd7, 32'h1234_5678, 4'b1111, 1'b1);
    step(30'd7, 32'h0000_00EF, 4'b0001, 1'b1);
    chk("bypass", a_rd, 32'h1234_56EF);

    step(30'h10, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    chk("oor_rd",  a_rd,           32'd0);
    chk("oor_err", {31'd0, a_err}, 32'd1);
    step(30'd0, 32'd0, 4'b0000, 1'b0);
    chk("oor_word0", a_rd,           32'd0);
    chk("oor_drop",  {31'd0, a_err}, 32'd0);

    for (int i = 0; i < 150; i++)
      step(30'($urandom_range(0, 19)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));

    // Reset while the fill counter sits at 9.
    reset_a();
    for (int i = 0; i < 9; i++) step(30'd0, 32'd0, 4'h0, 1'b0);
    reset_a();
    for (int i = 0; i < 16; i++) begin
      step(30'($urandom_range(0, 15)), $urandom, 4'hF, 1'b1);
      chk("reclear_ready", {31'd0, a_rdy}, (i == 15) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 40; i++)
      step(30'($urandom_range(0, 17)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));

    // Instance without zero-fill.
    @(posedge clk); #1;
    chk("b_rst_ready", {31'd0, b_rdy}, 32'd0);
    chk("b_rst_rd",    b_rd,           32'd0);
    b_rst   = 1'b0;
    bval    = $urandom;
    b_addr  = 30'd2; b_wdata = bval; b_mask = 4'hF; b_we = 1'b1;
    @(posedge clk); #1;
    chk("b_ready_first_edge", {31'd0, b_rdy}, 32'd1);
    chk("b_write_bypass",     b_rd,           bval);
    b_we = 1'b0; b_wdata = 32'd0;
    @(posedge clk); #1;
    chk("b_readback", b_rd,           bval);
    chk("b_err",      {31'd0, b_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
